// File: rtl/tone_sequencer.sv
// tone_sequencer: buzzer sequencer for the Tetris board.
// A looping background score plays through one square-wave output. Short
// event sound effects can be laid on top of it and mask it while they play.
// One reloadable half-period down-counter generates every tone.
// Optional feature macro: TONE_SEQ_SFX_EN. When it is defined, the effect
// channel (edge detectors, pattern storage, effect pointer and counter) is
// built. When it is not defined, only the background score plays and
// sfx_busy is tied low.
module tone_sequencer #(
    parameter int                       CLK_HZ      = 100_000_000,
    parameter int                       BEAT_CYCLES = 8_388_608,
    parameter int                       SCORE_LEN   = 157,
    parameter logic [SCORE_LEN*4-1:0]   SCORE       = {
        128'h33912219_88813321_99912233_11888800,
        128'h02246654_33313321_99912233_11888800,
        128'h33912219_88813321_99912233_11888800,
        128'h02246654_33313321_99912233_11888800,
        116'h33331111_22229999_11118888_99990
    },
    parameter int                       NUM_EVT     = 2,
    parameter logic [NUM_EVT*32-1:0]    EVT_PAT     = {32'h13500000, 32'h54321000}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bgm_en,
    input  logic [NUM_EVT-1:0] evt,
    output logic               note,
    output logic [3:0]         note_code,
    output logic               sfx_busy,
    output logic               beat_tick
);

    localparam int BCW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int PW  = (SCORE_LEN > 1) ? $clog2(SCORE_LEN) : 1;

    localparam logic [BCW-1:0] BC_LAST = BCW'(BEAT_CYCLES - 1);
    localparam logic [PW-1:0]  P_LAST  = PW'(SCORE_LEN - 1);

    // Half-period in clock cycles for each note code; 0 marks a rest.
    function automatic logic [31:0] half_period(input logic [3:0] code);
        case (code)
            4'd1:    half_period = 32'(CLK_HZ / (2 * 523));
            4'd2:    half_period = 32'(CLK_HZ / (2 * 587));
            4'd3:    half_period = 32'(CLK_HZ / (2 * 659));
            4'd4:    half_period = 32'(CLK_HZ / (2 * 698));
            4'd5:    half_period = 32'(CLK_HZ / (2 * 784));
            4'd6:    half_period = 32'(CLK_HZ / (2 * 880));
            4'd7:    half_period = 32'(CLK_HZ / (2 * 988));
            4'd8:    half_period = 32'(CLK_HZ / (2 * 440));
            4'd9:    half_period = 32'(CLK_HZ / (2 * 494));
            4'd10:   half_period = 32'(CLK_HZ / (2 * 1047));
            4'd11:   half_period = 32'(CLK_HZ / (2 * 1175));
            4'd12:   half_period = 32'(CLK_HZ / (2 * 1319));
            default: half_period = 32'd0;
        endcase
    endfunction

    // Codes 0 and 13..15 are silent.
    function automatic logic is_rest(input logic [3:0] code);
        is_rest = (code == 4'd0) || (code >= 4'd13);
    endfunction

    // Score step p; step 0 sits in the top nibble.
    function automatic logic [3:0] score_nib(input logic [PW-1:0] p);
        score_nib = SCORE[(SCORE_LEN - 1 - int'(p)) * 4 +: 4];
    endfunction

    // ------------------------------------------------------------------
    // Background score step counter and pointer
    // ------------------------------------------------------------------
    logic [BCW-1:0] bcnt_r, bcnt_s;
    logic [PW-1:0]  bptr_r, bptr_s;
    logic [3:0]     bgm_code_s;

    // Next step counter/pointer; both are held at zero while the score is off.
    always_comb begin
        bcnt_s = {BCW{1'b0}};
        bptr_s = {PW{1'b0}};
        if (bgm_en) begin
            if (bcnt_r == BC_LAST) begin
                bcnt_s = {BCW{1'b0}};
                bptr_s = (bptr_r == P_LAST) ? {PW{1'b0}} : bptr_r + PW'(1);
            end else begin
                bcnt_s = bcnt_r + BCW'(1);
                bptr_s = bptr_r;
            end
        end else begin
            bcnt_s = {BCW{1'b0}};
            bptr_s = {PW{1'b0}};
        end
    end

    // Score step registers and the registered end-of-step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_r      <= {BCW{1'b0}};
            bptr_r      <= {PW{1'b0}};
            beat_tick   <= 1'b0;
        end else begin
            bcnt_r      <= bcnt_s;
            bptr_r      <= bptr_s;
            beat_tick   <= bgm_en && (bcnt_s == BC_LAST);
        end
    end

    // The score sounds from the current pointer; a disabled score is silent.
    assign bgm_code_s = bgm_en ? score_nib(bptr_r) : 4'd0;

    // ------------------------------------------------------------------
    // Effect channel
    // ------------------------------------------------------------------
    logic       sfx_active_s;
    logic [3:0] sfx_code_s;

`ifdef TONE_SEQ_SFX_EN
    localparam int EW = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

    // Nibble k of effect e; effect 0 is the top word, nibble 0 plays first.
    function automatic logic [3:0] pat_nib(input logic [EW-1:0] e, input logic [2:0] k);
        pat_nib = EVT_PAT[(NUM_EVT - 1 - int'(e)) * 32 + (7 - int'(k)) * 4 +: 4];
    endfunction

    logic [NUM_EVT-1:0] prev_r;
    logic [NUM_EVT-1:0] trig_s;
    logic [EW-1:0]      win_s;
    logic               busy_r, busy_s;
    logic [2:0]         sptr_r, sptr_s;
    logic [BCW-1:0]     scnt_r, scnt_s;
    logic [EW-1:0]      sel_r, sel_s;

    assign trig_s = evt & ~prev_r;

    // Lowest-index rising edge wins when several arrive together.
    always_comb begin
        win_s = {EW{1'b0}};
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            win_s = trig_s[i] ? EW'(i) : win_s;
        end
    end

    // Effect sequencing: a trigger always restarts the channel, even when
    // the running effect would end in the same cycle.
    always_comb begin
        busy_s = busy_r;
        sptr_s = sptr_r;
        scnt_s = scnt_r;
        sel_s  = sel_r;
        if (|trig_s) begin
            busy_s = (pat_nib(win_s, 3'd0) != 4'd0);
            sptr_s = 3'd0;
            scnt_s = {BCW{1'b0}};
            sel_s  = win_s;
        end else if (busy_r) begin
            if (scnt_r == BC_LAST) begin
                scnt_s = {BCW{1'b0}};
                if (sptr_r == 3'd7) begin
                    busy_s = 1'b0;
                    sptr_s = 3'd0;
                end else begin
                    sptr_s = sptr_r + 3'd1;
                    busy_s = (pat_nib(sel_r, sptr_r + 3'd1) != 4'd0);
                end
            end else begin
                scnt_s = scnt_r + BCW'(1);
            end
        end else begin
            busy_s = 1'b0;
            sptr_s = 3'd0;
            scnt_s = {BCW{1'b0}};
        end
    end

    // Effect state; edge detectors start high so a held input never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= {NUM_EVT{1'b1}};
            busy_r <= 1'b0;
            sptr_r <= 3'd0;
            scnt_r <= {BCW{1'b0}};
            sel_r  <= {EW{1'b0}};
        end else begin
            prev_r <= evt;
            busy_r <= busy_s;
            sptr_r <= sptr_s;
            scnt_r <= scnt_s;
            sel_r  <= sel_s;
        end
    end

    // Use next-state values so the first nibble sounds one cycle after the edge.
    assign sfx_active_s = busy_s;
    assign sfx_code_s   = pat_nib(sel_s, sptr_s);
    assign sfx_busy     = busy_r;
`else
    logic unused_sfx_s;

    assign unused_sfx_s = ^{evt, EVT_PAT};
    assign sfx_active_s = 1'b0;
    assign sfx_code_s   = 4'd0;
    assign sfx_busy     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration and tone generator
    // ------------------------------------------------------------------
    logic [3:0]  code_s;
    logic [31:0] hcnt_r, hcnt_s;
    logic        note_s;

    // An effect masks the score; the score itself keeps advancing underneath.
    assign code_s = sfx_active_s ? sfx_code_s : bgm_code_s;

    // Half-period divider: reload on a code change, toggle on reaching zero,
    // and hold silent on rests.
    always_comb begin
        hcnt_s = hcnt_r;
        note_s = note;
        if (is_rest(code_s)) begin
            note_s = 1'b0;
            hcnt_s = 32'd0;
        end else if (code_s != note_code) begin
            hcnt_s = half_period(code_s) - 32'd1;
        end else if (hcnt_r == 32'd0) begin
            note_s = ~note;
            hcnt_s = half_period(code_s) - 32'd1;
        end else begin
            hcnt_s = hcnt_r - 32'd1;
        end
    end

    // Registered code, divider and buzzer output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_code <= 4'd0;
            hcnt_r    <= 32'd0;
            note      <= 1'b0;
        end else begin
            note_code <= code_s;
            hcnt_r    <= hcnt_s;
            note      <= note_s;
        end
    end

endmodule
